// File: rtl/argmax_l2.sv
// Sequential signed argmax over N_CLASSES snapshotted accumulators, one class per cycle.
// Define ARGMAX_SCORE_EN to also output the winning score and its margin over the runner-up.
module argmax_l2 #(
  parameter int N_CLASSES = 10,
  parameter int ACC_W     = 20,
  parameter int IDX_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_CLASSES*ACC_W-1:0]   acc_in_packed,
  output logic                         busy,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [IDX_W-1:0]             class_idx
`ifdef ARGMAX_SCORE_EN
  ,
  output logic signed [ACC_W-1:0]      max_score,
  output logic [ACC_W:0]               margin
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  state_t                  state_reg;
  logic signed [ACC_W-1:0] acc_in   [N_CLASSES];
  logic signed [ACC_W-1:0] snap_reg [N_CLASSES];
  logic signed [ACC_W-1:0] best_reg;
  logic signed [ACC_W-1:0] best_next;
  logic signed [ACC_W-1:0] cur;
  logic [IDX_W-1:0]        best_idx_reg;
  logic [IDX_W-1:0]        best_idx_next;
  logic [IDX_W-1:0]        ptr_reg;
  logic                    greater;

  genvar gi;
  generate
    for (gi = 0; gi < N_CLASSES; gi++) begin : g_unpack
      assign acc_in[gi] = acc_in_packed[gi*ACC_W +: ACC_W];
    end
  endgenerate

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    cur           = snap_reg[ptr_reg];
    greater       = (cur > best_reg);
    best_next     = greater ? cur : best_reg;
    best_idx_next = greater ? ptr_reg : best_idx_reg;
  end

`ifdef ARGMAX_SCORE_EN
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] second_reg;
  logic signed [ACC_W-1:0] second_next;
  logic [ACC_W:0]          margin_next;

  // One extra bit so best - second never wraps, even at the full signed range.
  always_comb begin
    second_next = greater ? best_reg : ((cur > second_reg) ? cur : second_reg);
    margin_next = {best_next[ACC_W-1], best_next} - {second_next[ACC_W-1], second_next};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      class_idx    <= '0;
      best_reg     <= '0;
      best_idx_reg <= '0;
      ptr_reg      <= '0;
      for (int i = 0; i < N_CLASSES; i++) snap_reg[i] <= '0;
`ifdef ARGMAX_SCORE_EN
      second_reg   <= '0;
      max_score    <= '0;
      margin       <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_CLASSES; i++) snap_reg[i] <= acc_in[i];
            best_reg     <= acc_in[0];
            best_idx_reg <= '0;
            ptr_reg      <= IDX_W'(1);
`ifdef ARGMAX_SCORE_EN
            second_reg   <= ACC_MIN;
`endif
            busy         <= 1'b1;
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          best_reg     <= best_next;
          best_idx_reg <= best_idx_next;
          ptr_reg      <= ptr_reg + IDX_W'(1);
`ifdef ARGMAX_SCORE_EN
          second_reg   <= second_next;
`endif
          if (ptr_reg == LAST_IDX) begin
            class_idx <= best_idx_next;
`ifdef ARGMAX_SCORE_EN
            max_score <= best_next;
            margin    <= margin_next;
`endif
            res_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_l2.sv
// Scoreboard bench for argmax_l2: expected results queued at start, compared when res_valid rises.
// Score outputs are checked when ARGMAX_SCORE_EN is defined.
module tb_argmax_l2;
  localparam int N  = 10;
  localparam int W  = 20;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              res_ready;
  logic [N*W-1:0]    acc_in_packed;
  logic              busy;
  logic              res_valid;
  logic [IW-1:0]     class_idx;
`ifdef ARGMAX_SCORE_EN
  logic signed [W-1:0] max_score;
  logic [W:0]          margin;
`endif

  argmax_l2 #(.N_CLASSES(N), .ACC_W(W), .IDX_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .acc_in_packed (acc_in_packed),
    .busy          (busy),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .class_idx     (class_idx)
`ifdef ARGMAX_SCORE_EN
    ,
    .max_score     (max_score),
    .margin        (margin)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint idx;
    longint mx;
    longint mg;
  } exp_t;

  exp_t   sb[$];
  longint vals[N];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: first index holding the maximum; runner-up is the max over every other index.
  task automatic push_expected();
    exp_t e;
    longint sec;
    e.idx = 0;
    for (int j = 1; j < N; j++) if (vals[j] > vals[e.idx]) e.idx = j;
    e.mx = vals[e.idx];
    sec = -(longint'(1) <<< (W-1));
    for (int j = 0; j < N; j++) if (j != e.idx && vals[j] > sec) sec = vals[j];
    e.mg = e.mx - sec;
    sb.push_back(e);
  endtask

  task automatic launch();
    @(negedge clk);
    for (int j = 0; j < N; j++) acc_in_packed[j*W +: W] = W'(vals[j]);
    start = 1'b1;
    push_expected();
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_in_packed = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_valid"}, res_valid, 0);
    check_eq({tag, "_idx"}, class_idx, 0);
`ifdef ARGMAX_SCORE_EN
    check_eq({tag, "_max"}, max_score, 0);
    check_eq({tag, "_margin"}, margin, 0);
`endif
  endtask

  // Waits (bounded) for res_valid, checks latency and result, optionally stresses
  // with ignored starts and a held-off res_ready, then completes the handshake.
  task automatic collect(input string tag, input bit stress, input int hold);
    exp_t e;
    int   cnt = 0;
    bit   found = 0;
    while (cnt < 40 && !found) begin
      @(negedge clk);
      cnt++;
      if (stress && cnt == 3) start = 1'b1;
      if (cnt == 4) start = 1'b0;
      if (res_valid) found = 1;
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, cnt, 10);
    e = sb.pop_front();
    if (!found) return;
    check_eq({tag, "_idx"}, class_idx, e.idx);
`ifdef ARGMAX_SCORE_EN
    check_eq({tag, "_max"}, max_score, e.mx);
    check_eq({tag, "_margin"}, margin, e.mg);
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      start = (k == 5);
    end
    if (hold > 0) begin
      check_eq({tag, "_hold_valid"}, res_valid, 1);
      check_eq({tag, "_hold_idx"}, class_idx, e.idx);
`ifdef ARGMAX_SCORE_EN
      check_eq({tag, "_hold_max"}, max_score, e.mx);
`endif
    end
    // Handshake with a coincident start, which must be dropped.
    @(negedge clk);
    res_ready = 1'b1;
    start     = stress;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    check_eq({tag, "_post_valid"}, res_valid, 0);
    check_eq({tag, "_post_busy"}, busy, 0);
    check_eq({tag, "_keep_idx"}, class_idx, e.idx);
    if (stress) begin
      repeat (3) @(negedge clk);
      check_eq({tag, "_no_queue"}, busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    res_ready = 1'b0;
    acc_in_packed = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: distinct values, winner at 7
    for (int j = 0; j < N; j++) vals[j] = j * 10;
    vals[7] = 500;
    launch();
    collect("distinct", 0, 0);
    $display("case distinct idx=%0d", class_idx);

    // 2: tie resolves to lowest index
    for (int j = 0; j < N; j++) vals[j] = 0;
    vals[2] = 300;
    vals[5] = 300;
    launch();
    collect("tie", 0, 0);
    $display("case tie idx=%0d", class_idx);

    // 3: all negative
    for (int j = 0; j < N; j++) vals[j] = -1000;
    vals[9] = -1;
    launch();
    collect("negative", 0, 0);
    $display("case negative idx=%0d", class_idx);

    // 4: full-range extremes
    for (int j = 0; j < N; j++) vals[j] = -524288;
    vals[0] = 524287;
    launch();
    collect("extremes", 0, 0);
    $display("case extremes idx=%0d", class_idx);

    // 5: backpressure with stray starts
    for (int j = 0; j < N; j++) vals[j] = 50 - j * 7;
    vals[4] = 123;
    launch();
    collect("backpressure", 1, 20);
    $display("case backpressure idx=%0d", class_idx);

    // 6: reset mid-scan aborts, then a fresh run completes
    for (int j = 0; j < N; j++) vals[j] = j;
    launch();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midscan_rst");
    void'(sb.pop_front());
    for (int j = 0; j < N; j++) vals[j] = 100 - j;
    vals[6] = 400;
    launch();
    collect("after_rst", 0, 0);
    $display("case after_rst idx=%0d", class_idx);

    // Random vectors
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < N; j++) vals[j] = longint'($signed(W'($urandom)));
      if (r == 3) vals[8] = vals[1];
      launch();
      collect("random", 0, r);
      $display("case random%0d idx=%0d", r, class_idx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
